com_bus_arbiter: RTL and testbench

COM_BUS_ARBITER -- requirements
Module: com_bus_arbiter

---
 rtl/com_bus_arbiter_if.sv | 25 ++
 rtl/com_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_com_bus_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/com_bus_arbiter_if.sv
// Shared request/grant bundle between the common-bus arbiter and its eight cache requesters
// plus the lower-level memory snoop port.
interface com_bus_arbiter_if;
    logic [7:0] Com_Bus_Req_proc;
    logic [7:0] Com_Bus_Req_snoop;
    logic       Mem_snoop_req;
    logic [7:0] Com_Bus_Gnt_proc;
    logic [7:0] Com_Bus_Gnt_snoop;
    logic       Mem_snoop_gnt;
    logic [2:0] Bus_owner;
    logic       Bus_busy;
    logic       Arb_err;

    // Arbiter side
    modport master (
        input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Bus_owner, Bus_busy, Arb_err
    );

    // Requester / memory side
    modport slave (
        output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Bus_owner, Bus_busy, Arb_err
    );
endinterface

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: round-robin proc ownership, fixed-priority snoop write-back and memory
// snoop slots nested inside an ownership; all outputs registered.
module com_bus_arbiter (
    input  logic               clk,
    input  logic               rst_n,
    com_bus_arbiter_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StProcGnt, StSnoopGnt, StMemGnt} state_e;

    state_e     state_q, state_d;
    logic [7:0] gnt_proc_q, gnt_proc_d;
    logic [7:0] gnt_snoop_q, gnt_snoop_d;
    logic       mem_gnt_q, mem_gnt_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic       rr_found;
    logic [2:0] rr_pick;
    logic [2:0] rr_idx;
    logic [7:0] snoop_elig;
    logic [2:0] snoop_pick;
    logic       owner_req;
    logic       owner_snoop;

    // Round-robin search starting at rr_ptr, wrapping modulo 8
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = 3'd0;
        rr_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            rr_idx = rr_ptr_q + 3'(i);
            if (!rr_found && bus.Com_Bus_Req_proc[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // Lowest-index snoop request other than the current owner
    always_comb begin
        snoop_elig = bus.Com_Bus_Req_snoop & ~(8'd1 << owner_q);
        snoop_pick = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (snoop_elig[i]) snoop_pick = 3'(i);
        end
    end

    assign owner_req   = bus.Com_Bus_Req_proc[owner_q];
    assign owner_snoop = bus.Com_Bus_Req_snoop[owner_q];

    always_comb begin
        state_d     = state_q;
        gnt_proc_d  = gnt_proc_q;
        gnt_snoop_d = gnt_snoop_q;
        mem_gnt_d   = mem_gnt_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|bus.Com_Bus_Req_snoop) begin
                    err_d = 1'b1;
                end else if (rr_found) begin
                    state_d    = StProcGnt;
                    owner_d    = rr_pick;
                    gnt_proc_d = 8'd1 << rr_pick;
                end
            end
            StProcGnt: begin
                if (owner_snoop) begin
                    err_d = 1'b1;
                end else if (!owner_req) begin
                    // Release always passes through IDLE so the next grant sees a turnaround cycle
                    state_d    = StIdle;
                    gnt_proc_d = '0;
                    owner_d    = 3'd0;
                    rr_ptr_d   = owner_q + 3'd1;
                end else if (|snoop_elig) begin
                    state_d     = StSnoopGnt;
                    gnt_snoop_d = 8'd1 << snoop_pick;
                end else if (bus.Mem_snoop_req) begin
                    state_d   = StMemGnt;
                    mem_gnt_d = 1'b1;
                end
            end
            StSnoopGnt: begin
                if (owner_snoop) begin
                    err_d = 1'b1;
                end else if (!(|(bus.Com_Bus_Req_snoop & gnt_snoop_q))) begin
                    state_d     = StProcGnt;
                    gnt_snoop_d = '0;
                end
            end
            StMemGnt: begin
                if (owner_snoop) begin
                    err_d = 1'b1;
                end else if (!bus.Mem_snoop_req) begin
                    state_d   = StProcGnt;
                    mem_gnt_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
                mem_gnt_d   = 1'b0;
                owner_d     = 3'd0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            mem_gnt_q   <= 1'b0;
            owner_q     <= 3'd0;
            rr_ptr_q    <= 3'd0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            mem_gnt_q   <= mem_gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.Com_Bus_Gnt_proc  = gnt_proc_q;
    assign bus.Com_Bus_Gnt_snoop = gnt_snoop_q;
    assign bus.Mem_snoop_gnt     = mem_gnt_q;
    assign bus.Bus_owner         = owner_q;
    assign bus.Bus_busy          = busy_q;
    assign bus.Arb_err           = err_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed scoreboard bench for com_bus_arbiter: stimulus queues the expected registered
// outputs for each edge, a monitor pops and compares just after the edge.
module tb_com_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    com_bus_arbiter_if bus_if ();

    com_bus_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gp;
        logic [7:0] gs;
        logic       mg;
        logic [2:0] own;
        logic       busy;
        logic       err;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        check({e.nm, ".gnt_proc"},  32'(bus_if.Com_Bus_Gnt_proc),  32'(e.gp));
        check({e.nm, ".gnt_snoop"}, 32'(bus_if.Com_Bus_Gnt_snoop), 32'(e.gs));
        check({e.nm, ".mem_gnt"},   32'(bus_if.Mem_snoop_gnt),     32'(e.mg));
        check({e.nm, ".owner"},     32'(bus_if.Bus_owner),         32'(e.own));
        check({e.nm, ".busy"},      32'(bus_if.Bus_busy),          32'(e.busy));
        check({e.nm, ".err"},       32'(bus_if.Arb_err),           32'(e.err));
    endtask

    // Monitor: pop one expectation per edge and compare, plus grant exclusivity invariants
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all(e);
                check({e.nm, ".snoop_onehot0"}, 32'($onehot0(bus_if.Com_Bus_Gnt_snoop)), 32'd1);
                check({e.nm, ".mem_snoop_excl"},
                      32'(bus_if.Mem_snoop_gnt && (|bus_if.Com_Bus_Gnt_snoop)), 32'd0);
            end
        end
    end

    // Drive inputs for the coming edge and queue the outputs expected after it
    task automatic step(input logic [7:0] rp, input logic [7:0] rs, input logic m,
                        input logic [7:0] gp, input logic [7:0] gs, input logic mg,
                        input logic [2:0] own, input logic busy, input logic err,
                        input string nm);
        exp_t e;
        @(negedge clk);
        bus_if.Com_Bus_Req_proc  = rp;
        bus_if.Com_Bus_Req_snoop = rs;
        bus_if.Mem_snoop_req     = m;
        e.gp = gp; e.gs = gs; e.mg = mg; e.own = own; e.busy = busy; e.err = err; e.nm = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] oh;
        exp_t z;
        z.gp = '0; z.gs = '0; z.mg = 1'b0; z.own = 3'd0; z.busy = 1'b0; z.err = 1'b0;

        bus_if.Com_Bus_Req_proc  = '0;
        bus_if.Com_Bus_Req_snoop = '0;
        bus_if.Mem_snoop_req     = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        z.nm = "reset";
        check_all(z);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin 0..7,0 with one idle turnaround cycle after each release
        for (int i = 0; i < 9; i++) begin
            oh = 8'd1 << (i % 8);
            step(8'hFF, 8'h00, 1'b0, oh, 8'h00, 1'b0, 3'(i % 8), 1'b1, 1'b0, "rr_grant");
            step(8'hFF & ~oh, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "rr_release");
        end

        // Wrap: rr_ptr=1, owner 7 releases while 7 and 2 request; next grant must be 2
        step(8'h80, 8'h00, 1'b0, 8'h80, 8'h00, 1'b0, 3'd7, 1'b1, 1'b0, "wrap_grant7");
        step(8'h84, 8'h00, 1'b0, 8'h80, 8'h00, 1'b0, 3'd7, 1'b1, 1'b0, "wrap_hold7");
        step(8'h04, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "wrap_release7");
        step(8'h84, 8'h00, 1'b0, 8'h04, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, "wrap_grant2");
        step(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "wrap_release2");

        // Snoop priority over memory, fixed priority among snoops (rr_ptr=3 -> owner 0)
        step(8'h01, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, "sp_grant0");
        step(8'h01, 8'h0A, 1'b1, 8'h01, 8'h02, 1'b0, 3'd0, 1'b1, 1'b0, "sp_snoop1");
        step(8'h01, 8'h08, 1'b1, 8'h01, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, "sp_back_proc");
        step(8'h01, 8'h08, 1'b1, 8'h01, 8'h08, 1'b0, 3'd0, 1'b1, 1'b0, "sp_snoop3");
        step(8'h01, 8'h00, 1'b1, 8'h01, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, "sp_back_proc2");
        step(8'h01, 8'h00, 1'b1, 8'h01, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, "sp_mem");
        step(8'h01, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, "sp_mem_done");
        step(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "sp_release0");

        // Memory path with owner 4 (rr_ptr=1); extra proc requests must not preempt
        step(8'h10, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, "mem_grant4");
        step(8'h13, 8'h00, 1'b1, 8'h10, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, "mem_c1");
        step(8'h13, 8'h00, 1'b1, 8'h10, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, "mem_c2");
        step(8'h13, 8'h00, 1'b1, 8'h10, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, "mem_c3");
        step(8'h13, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, "mem_back_proc");
        step(8'h13, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, "no_preempt");

        // Errors: snoop[owner] while granted, then snoop in IDLE
        step(8'h13, 8'h10, 1'b0, 8'h10, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1, "err_owner");
        step(8'h13, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, "err_owner_end");
        step(8'h03, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "release4");
        step(8'h03, 8'h20, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, "err_idle");
        step(8'h03, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, "grant0_from5");
        step(8'h02, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "release0");

        // Reset in the middle of a snoop grant
        step(8'h02, 8'h00, 1'b0, 8'h02, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0, "rst_grant1");
        step(8'h02, 8'h01, 1'b0, 8'h02, 8'h01, 1'b0, 3'd1, 1'b1, 1'b0, "rst_snoop0");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        z.nm = "async_reset";
        check_all(z);
        bus_if.Com_Bus_Req_proc  = '0;
        bus_if.Com_Bus_Req_snoop = '0;
        bus_if.Mem_snoop_req     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h01, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, "post_reset_grant");
        step(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, "post_reset_release");

        @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
